// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: symmetric FIR built around one shared multiplier.
// Each accepted sample shifts the delay line, then NTAPS cycles fold each
// symmetric tap pair through the pre-adder and multiply it by one ROM
// coefficient. One more cycle saturates the accumulator into y.
//
// Ports:
//   sys_clk, reset   clock and synchronous active-high reset
//   in_valid, x_in   input sample strobe and 1s17 sample
//   in_ready         high only while idle
//   coef_addr        coefficient index to the external ROM (0 when not running)
//   coef_data        0s18 coefficient, combinational from coef_addr
//   y, out_valid     1s17 output, held between updates, and its 1-cycle pulse
//   overrun          1-cycle pulse for a sample dropped while busy
//   overrun_cnt      saturating count of dropped samples
module fir_mac_sequencer #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned LENGTH = 15,
  parameter int unsigned ACC_W  = 22,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    in_ready,
  output logic [((LENGTH+1)/2 > 1 ? $clog2((LENGTH+1)/2) : 1)-1:0] coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  output logic signed [WIDTH-1:0] y,
  output logic                    out_valid,
  output logic                    overrun,
  output logic [CNT_W-1:0]        overrun_cnt
);

  localparam int unsigned NTAPS = (LENGTH + 1) / 2;
  localparam int unsigned AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_x [LENGTH];
  logic signed [ACC_W-1:0]   r_acc;
  logic [AW-1:0]             r_cnt;
  logic                      r_in_ready;
  logic signed [WIDTH-1:0]   r_y;
  logic                      r_out_valid;
  logic                      r_overrun;
  logic [CNT_W-1:0]          r_overrun_cnt;

  logic signed [WIDTH-1:0]   w_x_lo;
  logic signed [WIDTH-1:0]   w_x_hi;
  logic signed [WIDTH-1:0]   w_pre;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [WIDTH-1:0]   w_y_sat;
  logic                      w_unused;

  // Tap-pair select; constant indices keep the mux free of index-width issues.
  always_comb begin
    w_x_lo = '0;
    w_x_hi = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      if (r_cnt == AW'(i)) begin
        w_x_lo = r_x[i];
        w_x_hi = r_x[LENGTH-1-i];
      end
    end
  end

  // Delay-line values are 2s16, so a pair sum always fits 18 bits.
  // The centre tap has no partner and passes through alone.
  assign w_pre  = (r_cnt == AW'(NTAPS-1)) ? w_x_lo : w_x_lo + w_x_hi;
  assign w_prod = PW'(coef_data) * PW'(w_pre);
  // 2s34 product truncated to its 1s17 slice, then sign-extended.
  assign w_term = ACC_W'(signed'(w_prod[PW-2:WIDTH-1]));

  assign w_y_sat = (r_acc > ACC_W'(Y_MAX)) ? Y_MAX :
                   (r_acc < ACC_W'(Y_MIN)) ? Y_MIN : WIDTH'(r_acc);

  assign w_unused = ^{w_prod[PW-1], w_prod[WIDTH-2:0], x_in[0]};

  // Sequencer, datapath and status registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < int'(LENGTH); i++) r_x[i] <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_y           <= '0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      if (in_valid && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
        if (r_overrun_cnt != '1) r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0] <= {x_in[WIDTH-1], x_in[WIDTH-1:1]};
            for (int i = 1; i < int'(LENGTH); i++) r_x[i] <= r_x[i-1];
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_term;
          if (r_cnt == AW'(NTAPS-1)) r_state <= S_DONE;
          else                       r_cnt   <= r_cnt + AW'(1);
        end
        S_DONE: begin
          r_y         <= w_y_sat;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign coef_addr   = (r_state == S_RUN) ? r_cnt : '0;
  assign y           = r_y;
  assign out_valid   = r_out_valid;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vectors against hand-computed outputs.
// Inputs are driven and outputs sampled on the falling edge of sys_clk.
module tb_fir_mac_sequencer;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [17:0] x_in;
  logic               in_ready;
  logic [2:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic signed [17:0] y;
  logic               out_valid;
  logic               overrun;
  logic [7:0]         overrun_cnt;

  logic signed [17:0] rom [8];
  int                 checks   = 0;
  int                 failures = 0;
  int                 pulse_cnt = 0;

  fir_mac_sequencer dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .x_in        (x_in),
    .in_ready    (in_ready),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .y           (y),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  assign coef_data = rom[coef_addr];

  always @(negedge sys_clk) if (out_valid) pulse_cnt <= pulse_cnt + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; x_in = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic set_rom(input logic signed [17:0] centre, input logic signed [17:0] k0,
                         input logic signed [17:0] others);
    for (int k = 0; k < 8; k++) rom[k] = others;
    rom[0] = k0;
    rom[7] = centre;
  endtask

  // One sample on a 12-cycle period; checks RUN addressing, latency and y.
  task automatic send_sample(input string tag, input logic signed [17:0] xv,
                             input longint exp_y, input bit chk_addr);
    in_valid = 1'b1; x_in = xv;
    tick(1);
    in_valid = 1'b0; x_in = '0;
    for (int k = 0; k < 8; k++) begin
      if (chk_addr) check_val({tag, " coef_addr"}, longint'(coef_addr), longint'(k));
      tick(1);
    end
    check_val({tag, " early out_valid"}, longint'(out_valid), 0);
    tick(1);
    check_val({tag, " out_valid"}, longint'(out_valid), 1);
    check_val({tag, " y"}, longint'(y), exp_y);
    tick(2);
  endtask

  initial begin
    int p0;
    reset = 1'b1; in_valid = 1'b0; x_in = '0;
    for (int k = 0; k < 8; k++) rom[k] = '0;
    tick(2);
    reset = 1'b0;
    tick(1);

    check_val("rst y", longint'(y), 0);
    check_val("rst out_valid", longint'(out_valid), 0);
    check_val("rst in_ready", longint'(in_ready), 1);
    check_val("rst overrun_cnt", longint'(overrun_cnt), 0);
    check_val("rst coef_addr", longint'(coef_addr), 0);

    // Positive impulse through centre tap
    set_rom(18'sd131071, 18'sd0, 18'sd0);
    p0 = pulse_cnt;
    for (int j = 0; j < 15; j++)
      send_sample($sformatf("imp+ %0d", j), (j == 0) ? 18'sd131071 : 18'sd0,
                  (j == 7) ? 65534 : 0, 1'b0);
    tick(2);
    check_val("imp+ pulses", longint'(pulse_cnt - p0), 15);

    // Negative full-scale impulse
    do_reset();
    for (int j = 0; j < 15; j++)
      send_sample($sformatf("imp- %0d", j), (j == 0) ? -18'sd131072 : 18'sd0,
                  (j == 7) ? -65536 : 0, 1'b0);

    // Symmetric outer pair
    do_reset();
    set_rom(18'sd0, -18'sd348, 18'sd0);
    for (int j = 0; j < 15; j++)
      send_sample($sformatf("sym %0d", j), (j == 0) ? 18'sd131071 : 18'sd0,
                  (j == 0 || j == 14) ? -174 : 0, 1'b1);

    // Saturation under DC full scale
    do_reset();
    set_rom(18'sd131071, 18'sd131071, 18'sd131071);
    for (int j = 0; j < 16; j++)
      send_sample($sformatf("sat %0d", j), 18'sd131071,
                  (j == 0) ? 65534 : (j == 1) ? 131068 : 131071, 1'b0);

    // Reset mid-RUN, with in_valid asserted alongside reset
    p0 = pulse_cnt;
    in_valid = 1'b1; x_in = 18'sd131071;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    reset = 1'b1; in_valid = 1'b1;
    tick(2);
    reset = 1'b0; in_valid = 1'b0;
    check_val("midrst in_ready", longint'(in_ready), 1);
    check_val("midrst y", longint'(y), 0);
    check_val("midrst overrun_cnt", longint'(overrun_cnt), 0);
    tick(14);
    check_val("midrst pulses", longint'(pulse_cnt - p0), 0);
    check_val("midrst overrun_cnt late", longint'(overrun_cnt), 0);

    // Overrun and latency: valid at cycles 0 and 3, then 10
    do_reset();
    set_rom(18'sd0, 18'sd0, 18'sd0);
    in_valid = 1'b1;                      // cycle 0
    tick(1);
    in_valid = 1'b0;
    tick(2);
    in_valid = 1'b1;                      // cycle 3
    tick(1);
    in_valid = 1'b0;                      // cycle 4
    check_val("ovr pulse", longint'(overrun), 1);
    check_val("ovr cnt", longint'(overrun_cnt), 1);
    for (int c = 5; c < 10; c++) begin
      tick(1);
      check_val($sformatf("ovr quiet %0d", c), longint'(out_valid | overrun), 0);
    end
    tick(1);                              // cycle 10
    check_val("ovr out_valid c10", longint'(out_valid), 1);
    check_val("ovr in_ready c10", longint'(in_ready), 1);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check_val("b2b overrun", longint'(overrun), 0);
    check_val("b2b in_ready", longint'(in_ready), 0);
    check_val("b2b cnt", longint'(overrun_cnt), 1);
    tick(9);                              // cycle 20
    check_val("b2b out_valid c20", longint'(out_valid), 1);

    // Held in_valid drives the counter into saturation
    in_valid = 1'b1;
    tick(400);
    in_valid = 1'b0;
    tick(12);
    check_val("ovr sat", longint'(overrun_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
